// File: rtl/uart_gpio_fab_lock_rst_seq.sv
// Purpose: PLL lock supervisor; qualifies synchronised LOCK and releases fabric then peripheral resets.
// Latency: FAB_RESET_N rises 1+2+STABLE_CYCLES cycles after RESET falls with LOCK high, PERIPH_RESET_N RELEASE_GAP later.
// Backpressure: none; all outputs are registered status/reset levels. Define UART_GPIO_FAB_LOCK_LOSS_CNT_EN to build LOSS_CNT.
module uart_gpio_fab_lock_rst_seq #(
    parameter int STABLE_CYCLES = 16,
    parameter int RELEASE_GAP   = 8,
    parameter int LOSS_FILTER   = 4,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int LOSS_CNT_W    = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  LOCK,
    output logic                  FAB_RESET_N,
    output logic                  PERIPH_RESET_N,
    output logic                  READY,
    output logic                  LOCK_TMO,
    output logic [LOSS_CNT_W-1:0] LOSS_CNT
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int GW = $clog2(RELEASE_GAP + 1);
    localparam int FW = $clog2(LOSS_FILTER + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t          state, state_nxt;
    logic            lock_m, lock_s;
    logic [SW-1:0]   stable_cnt, stable_nxt;
    logic [GW-1:0]   gap_cnt, gap_nxt;
    logic [FW-1:0]   low_cnt, low_nxt;
    logic [TW-1:0]   tmo_cnt, tmo_nxt;
    logic            tmo_flag_nxt;
    logic            loss_evt;
    logic            loss_hit;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge CLK) begin
        if (RESET) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= LOCK;
            lock_s <= lock_m;
        end
    end

    // Loss is qualified once the low-run count reaches LOSS_FILTER this cycle
    assign loss_hit = !lock_s && (low_cnt == FW'(LOSS_FILTER - 1));

    // Next-state, counter updates and loss event decode
    always_comb begin
        state_nxt    = state;
        stable_nxt   = stable_cnt;
        gap_nxt      = gap_cnt;
        low_nxt      = low_cnt;
        tmo_nxt      = tmo_cnt;
        tmo_flag_nxt = LOCK_TMO;
        loss_evt     = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_WAIT_LOCK;
                tmo_nxt   = '0;
            end
            ST_WAIT_LOCK: begin
                if (tmo_cnt != TW'(LOCK_TIMEOUT))
                    tmo_nxt = tmo_cnt + TW'(1);
                if (tmo_cnt == TW'(LOCK_TIMEOUT - 1))
                    tmo_flag_nxt = 1'b1;
                if (lock_s) begin
                    state_nxt  = ST_STABLE;
                    stable_nxt = '0;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    // Dropout before release is just a requalify, not a counted loss
                    state_nxt = ST_WAIT_LOCK;
                    tmo_nxt   = '0;
                end else if (stable_cnt == SW'(STABLE_CYCLES - 1)) begin
                    state_nxt = ST_RELEASE;
                    gap_nxt   = '0;
                    low_nxt   = '0;
                end else begin
                    stable_nxt = stable_cnt + SW'(1);
                end
            end
            ST_RELEASE, ST_RUN: begin
                low_nxt = lock_s ? '0 : low_cnt + FW'(1);
                if (loss_hit) begin
                    // Loss takes priority over a gap completing in the same cycle
                    state_nxt = ST_WAIT_LOCK;
                    tmo_nxt   = '0;
                    low_nxt   = '0;
                    loss_evt  = 1'b1;
                end else if (state == ST_RELEASE) begin
                    if (gap_cnt == GW'(RELEASE_GAP - 1))
                        state_nxt = ST_RUN;
                    else
                        gap_nxt = gap_cnt + GW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= ST_IDLE;
            stable_cnt     <= '0;
            gap_cnt        <= '0;
            low_cnt        <= '0;
            tmo_cnt        <= '0;
            LOCK_TMO       <= 1'b0;
            FAB_RESET_N    <= 1'b0;
            PERIPH_RESET_N <= 1'b0;
            READY          <= 1'b0;
        end else begin
            state          <= state_nxt;
            stable_cnt     <= stable_nxt;
            gap_cnt        <= gap_nxt;
            low_cnt        <= low_nxt;
            tmo_cnt        <= tmo_nxt;
            LOCK_TMO       <= tmo_flag_nxt;
            FAB_RESET_N    <= (state_nxt == ST_RELEASE) || (state_nxt == ST_RUN);
            PERIPH_RESET_N <= (state_nxt == ST_RUN);
            READY          <= (state_nxt == ST_RUN);
        end
    end

`ifdef UART_GPIO_FAB_LOCK_LOSS_CNT_EN
    // Saturating count of qualified lock-loss events
    always_ff @(posedge CLK) begin
        if (RESET)
            LOSS_CNT <= '0;
        else if (loss_evt && (LOSS_CNT != {LOSS_CNT_W{1'b1}}))
            LOSS_CNT <= LOSS_CNT + LOSS_CNT_W'(1);
    end
`else
    logic loss_evt_unused;
    assign loss_evt_unused = loss_evt;
    assign LOSS_CNT        = '0;
`endif

endmodule
